// File: rtl/bp_me_wormhole_packet_decode_lce_req.sv
// bp_me_wormhole_packet_decode_lce_req
// CCE-side receiver for LCE request wormhole packets.
// Reassembles a packet flit by flit into a single buffer, then presents the
// BedRock LCE request header and payload as one valid/yumi message.
// The buffer holds one packet only; the next packet is refused until the
// current message is taken.
module bp_me_wormhole_packet_decode_lce_req #(
  parameter int flit_width_p    = 64,
  parameter int cord_width_p    = 7,
  parameter int cid_width_p     = 2,
  parameter int len_width_p     = 4,
  parameter int msg_hdr_width_p = 107,
  parameter int data_width_p    = 512
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [flit_width_p-1:0]    link_data_i,
  input  logic                       link_v_i,
  output logic                       link_ready_and_o,
  output logic [msg_hdr_width_p-1:0] msg_hdr_o,
  output logic [data_width_p-1:0]    data_o,
  output logic                       v_o,
  input  logic                       yumi_i
);

  // Packed image layout, LSB first: cord, cid, len, msg_hdr, data
  localparam int len_off_lp   = cord_width_p + cid_width_p;
  localparam int hdr_off_lp   = len_off_lp + len_width_p;
  localparam int wh_hdr_lp    = hdr_off_lp + msg_hdr_width_p;
  localparam int max_len_lp   = ((wh_hdr_lp + data_width_p + flit_width_p - 1) / flit_width_p) - 1;
  localparam int buf_width_lp = (max_len_lp + 1) * flit_width_p;

  typedef enum logic [1:0] {
    e_ready,
    e_collect,
    e_output
  } state_e;

  state_e                   r_state;
  logic [len_width_p-1:0]   r_cnt;
  logic [len_width_p-1:0]   r_len;
  logic [buf_width_lp-1:0]  r_buf;

  logic                     w_xfer;
  logic [len_width_p-1:0]   w_len_in;

  // The cord/cid fields and the pad above the payload are stored with their
  // flits but never read out; this tap marks them as intentionally unread.
  logic [buf_width_lp-1:0]  w_buf_unused;

  assign w_xfer       = link_v_i & link_ready_and_o;
  assign w_len_in     = link_data_i[len_off_lp +: len_width_p];
  assign w_buf_unused = r_buf;

  // Handshake outputs come straight from the state register
  assign link_ready_and_o = (r_state != e_output);
  assign v_o              = (r_state == e_output);

  // Message fields are fixed slices of the reassembled image
  assign msg_hdr_o = r_buf[hdr_off_lp +: msg_hdr_width_p];
  assign data_o    = r_buf[wh_hdr_lp +: data_width_p];

  // Packet FSM: capture the head flit, collect body flits, hold until yumi
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= e_ready;
      r_cnt   <= '0;
      r_len   <= '0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        e_ready: begin
          if (w_xfer) begin
            r_buf <= {{(buf_width_lp - flit_width_p){1'b0}}, link_data_i};
            r_len <= w_len_in;
            if (w_len_in == '0) begin
              r_cnt   <= '0;
              r_state <= e_output;
            end else begin
              r_cnt   <= len_width_p'(1);
              r_state <= e_collect;
            end
          end
        end
        e_collect: begin
          if (w_xfer) begin
            for (int k = 1; k <= max_len_lp; k++) begin
              if (r_cnt == len_width_p'(k)) begin
                r_buf[k*flit_width_p +: flit_width_p] <= link_data_i;
              end
            end
            if (r_cnt == r_len) begin
              r_cnt   <= '0;
              r_state <= e_output;
            end else begin
              r_cnt   <= r_cnt + len_width_p'(1);
            end
          end
        end
        e_output: begin
          if (yumi_i) begin
            r_state <= e_ready;
          end
        end
        default: begin
          r_state <= e_ready;
        end
      endcase
    end
  end

  // Flag packets longer than the buffer (excess flits are dropped) and
  // yumi pulses that arrive with no message to take
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (w_xfer && (r_state == e_ready)) begin
        assert (int'(w_len_in) <= max_len_lp);
      end
      assert (!(yumi_i && !v_o));
    end
  end

endmodule

// File: tb/tb_bp_me_wormhole_packet_decode_lce_req.sv
// tb_bp_me_wormhole_packet_decode_lce_req
// Drives LCE request packets built by a golden encoder and compares each
// emitted message against the packet bits that were actually carried.
module tb_bp_me_wormhole_packet_decode_lce_req;

  localparam int FW    = 64;
  localparam int HDRW  = 107;
  localparam int DATAW = 512;
  localparam int IMGW  = 640;
  localparam int NRND  = 200;

  typedef struct {
    logic [HDRW-1:0]  hdr;
    logic [DATAW-1:0] data;
  } msg_t;

  logic             clk;
  logic             reset_i;
  logic [FW-1:0]    link_data_i;
  logic             link_v_i;
  logic             link_ready_and_o;
  logic [HDRW-1:0]  msg_hdr_o;
  logic [DATAW-1:0] data_o;
  logic             v_o;
  logic             yumi_i;

  int   total;
  int   bad;
  bit   drvTimeout;
  msg_t expQ[$];

  bp_me_wormhole_packet_decode_lce_req dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .link_data_i      (link_data_i),
    .link_v_i         (link_v_i),
    .link_ready_and_o (link_ready_and_o),
    .msg_hdr_o        (msg_hdr_o),
    .data_o           (data_o),
    .v_o              (v_o),
    .yumi_i           (yumi_i)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it disagrees
  task automatic checkOutput(input string tag, input logic [DATAW-1:0] got, input logic [DATAW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATAW-1:0] rand512();
    logic [DATAW-1:0] v;
    for (int i = 0; i < DATAW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [HDRW-1:0] randHdr();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = $urandom;
    return v[HDRW-1:0];
  endfunction

  // Golden encoder: pack the fields, then keep only the bits that the
  // packet's (len+1) flits actually carry
  function automatic logic [IMGW-1:0] buildImage(input logic [6:0] cord, input logic [1:0] cid,
                                                 input logic [3:0] len, input logic [HDRW-1:0] hdr,
                                                 input logic [DATAW-1:0] data);
    logic [IMGW-1:0] img;
    logic [IMGW-1:0] one;
    logic [IMGW-1:0] mask;
    int              nbits;
    img   = {8'b0, data, hdr, len, cid, cord};
    nbits = (int'(len) + 1) * FW;
    one   = 1;
    if (nbits >= IMGW) mask = '1;
    else mask = (one << nbits) - one;
    return img & mask;
  endfunction

  function automatic msg_t expectOf(input logic [IMGW-1:0] img);
    msg_t m;
    m.hdr  = img[119:13];
    m.data = img[631:120];
    return m;
  endfunction

  // Send the first nFlits flits of an image; called and returns on a negedge
  task automatic applyStimulus(input logic [IMGW-1:0] img, input int nFlits,
                               input int gapMin, input int gapMax, input bit chk);
    for (int k = 0; k < nFlits; k++) begin
      int gap;
      int w;
      gap = $urandom_range(gapMax, gapMin);
      link_v_i = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (chk) checkOutput("gap_ready", DATAW'(link_ready_and_o), DATAW'(1));
      end
      link_v_i    = 1'b1;
      link_data_i = img[k*FW +: FW];
      if (chk) checkOutput("busy_v", DATAW'(v_o), DATAW'(0));
      w = 0;
      while (!link_ready_and_o && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!link_ready_and_o) begin
        checkOutput("drv_timeout", DATAW'(0), DATAW'(1));
        drvTimeout = 1'b1;
        link_v_i   = 1'b0;
        return;
      end
      @(negedge clk);
    end
    link_v_i = 1'b0;
  endtask

  // Check the held message, then take it with a one-cycle yumi
  task automatic expectMsg(input string tag, input msg_t m);
    checkOutput({tag, "_v"}, DATAW'(v_o), DATAW'(1));
    checkOutput({tag, "_hdr"}, DATAW'(msg_hdr_o), DATAW'(m.hdr));
    checkOutput({tag, "_data"}, data_o, m.data);
    yumi_i = 1'b1;
    @(negedge clk);
    yumi_i = 1'b0;
    checkOutput({tag, "_vdrop"}, DATAW'(v_o), DATAW'(0));
  endtask

  // Directed cases followed by a randomized stream
  initial begin
    logic [IMGW-1:0] img;
    logic [IMGW-1:0] imgB;
    msg_t            m;
    msg_t            mB;

    total       = 0;
    bad         = 0;
    drvTimeout  = 1'b0;
    reset_i     = 1'b1;
    link_v_i    = 1'b0;
    link_data_i = '0;
    yumi_i      = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;

    checkOutput("rst_v", DATAW'(v_o), DATAW'(0));
    checkOutput("rst_ready", DATAW'(link_ready_and_o), DATAW'(1));
    checkOutput("rst_hdr", DATAW'(msg_hdr_o), DATAW'(0));
    checkOutput("rst_data", data_o, DATAW'(0));

    $display("[TB] header-only read, len=1, back to back");
    img = buildImage(7'h15, 2'd1, 4'd1, randHdr(), '0);
    applyStimulus(img, 2, 0, 0, 1'b1);
    expectMsg("t1", expectOf(img));

    $display("[TB] uc_wr size_8, len=2, two idle cycles between flits");
    img = buildImage(7'h03, 2'd2, 4'd2, randHdr(), DATAW'(64'hDEAD_BEEF_0123_4567));
    applyStimulus(img, 3, 2, 2, 1'b1);
    m = expectOf(img);
    checkOutput("t2_upper_zero", DATAW'(data_o[511:64]), DATAW'(0));
    expectMsg("t2", m);

    $display("[TB] full 64B packet, len=9");
    img = buildImage(7'h7f, 2'd3, 4'd9, randHdr(), rand512());
    applyStimulus(img, 10, 0, 0, 1'b0);
    expectMsg("t3", expectOf(img));

    $display("[TB] backpressure with next packet waiting");
    img  = buildImage(7'h11, 2'd0, 4'd1, randHdr(), rand512());
    imgB = buildImage(7'h22, 2'd1, 4'd1, randHdr(), rand512());
    m    = expectOf(img);
    mB   = expectOf(imgB);
    applyStimulus(img, 2, 0, 0, 1'b0);
    link_v_i    = 1'b1;
    link_data_i = imgB[FW-1:0];
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_ready", DATAW'(link_ready_and_o), DATAW'(0));
      checkOutput("bp_v", DATAW'(v_o), DATAW'(1));
      checkOutput("bp_hdr", DATAW'(msg_hdr_o), DATAW'(m.hdr));
      checkOutput("bp_data", data_o, m.data);
      @(negedge clk);
    end
    yumi_i = 1'b1;
    @(negedge clk);
    yumi_i = 1'b0;
    checkOutput("bp_release_ready", DATAW'(link_ready_and_o), DATAW'(1));
    checkOutput("bp_release_v", DATAW'(v_o), DATAW'(0));
    @(negedge clk);
    checkOutput("bp_head_taken", DATAW'(link_ready_and_o), DATAW'(1));
    link_data_i = imgB[2*FW-1:FW];
    @(negedge clk);
    link_v_i = 1'b0;
    expectMsg("t4b", mB);

    $display("[TB] reset in the middle of a packet");
    img = buildImage(7'h05, 2'd2, 4'd2, randHdr(), rand512());
    applyStimulus(img, 2, 0, 0, 1'b0);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    checkOutput("t5_rst_v", DATAW'(v_o), DATAW'(0));
    checkOutput("t5_rst_ready", DATAW'(link_ready_and_o), DATAW'(1));
    checkOutput("t5_rst_hdr", DATAW'(msg_hdr_o), DATAW'(0));
    checkOutput("t5_rst_data", data_o, DATAW'(0));
    img = buildImage(7'h06, 2'd1, 4'd1, randHdr(), rand512());
    applyStimulus(img, 2, 0, 0, 1'b1);
    expectMsg("t5", expectOf(img));

    $display("[TB] random stream of %0d packets", NRND);
    fork
      begin : driver
        for (int n = 0; n < NRND && !drvTimeout; n++) begin
          logic [3:0] len;
          len = 4'($urandom_range(9, 0));
          img = buildImage(7'($urandom), 2'($urandom), len, randHdr(), rand512());
          expQ.push_back(expectOf(img));
          applyStimulus(img, int'(len) + 1, 0, 2, 1'b0);
        end
      end
      begin : consumer
        int   got;
        int   cyc;
        int   delay;
        bit   seen;
        msg_t cur;
        got   = 0;
        cyc   = 0;
        delay = 0;
        seen  = 1'b0;
        cur.hdr  = '0;
        cur.data = '0;
        while (got < NRND && cyc < 30000 && !drvTimeout) begin
          @(negedge clk);
          cyc++;
          yumi_i = 1'b0;
          if (v_o) begin
            if (!seen) begin
              if (expQ.size() == 0) begin
                checkOutput("rnd_extra", DATAW'(1), DATAW'(0));
              end else begin
                cur = expQ.pop_front();
                checkOutput("rnd_hdr", DATAW'(msg_hdr_o), DATAW'(cur.hdr));
                checkOutput("rnd_data", data_o, cur.data);
              end
              seen  = 1'b1;
              delay = $urandom_range(3, 0);
            end else begin
              checkOutput("rnd_hold_hdr", DATAW'(msg_hdr_o), DATAW'(cur.hdr));
            end
            if (delay == 0) begin
              yumi_i = 1'b1;
              seen   = 1'b0;
              got++;
            end else begin
              delay--;
            end
          end
        end
        @(negedge clk);
        yumi_i = 1'b0;
        checkOutput("rnd_count", DATAW'(got), DATAW'(NRND));
      end
    join
    checkOutput("rnd_leftover", DATAW'(expQ.size()), DATAW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
